lsu_dmem_port: RTL and testbench

- Load/store unit that sits directly upstream of the word-addressed data memory (dmem) and drives its write_en/addr/write_data/read_data port.
- Converts pipeline byte, halfword and word loads and stores into aligned 32-bit dmem accesses.
- Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
- Misaligned, out-of-range and illegal-size requests are rejected before they reach dmem.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_lane_align.sv | 35 +++
 rtl/lsu_dmem_port.sv | 169 ++++++++++++++++
 tb/tb_lsu_dmem_port.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: request sizes and FSM states.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        RESP   = 2'b11
    } state_e;

    function automatic logic [2:0] size_bytes(input size_e sz);
        case (sz)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extract with sign/zero extension, and lane merge for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane  = rdata[{offset, 3'b000} +: 8];
        half_lane  = rdata[{offset[1], 4'b0000} +: 16];
        load_data  = rdata;
        merge_data = rdata;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
                merge_data[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
                merge_data[{offset[1], 4'b0000} +: 16] = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_port.sv
// Load/store unit front-end for a word-addressed dmem: checks requests, does RMW for sub-word stores.
module lsu_dmem_port
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    size_e       size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] wdata_q, wdata_d;

    logic        ready_q, ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    size_e       req_sz;
    logic        req_bad;
    logic [32:0] req_end;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    lsu_lane_align u_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .offset      (off_q),
        .rdata       (mem_read_data),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    // 33-bit end address so requests near the top of the address space cannot wrap into range
    always_comb begin
        req_sz  = size_e'(req_size);
        req_end = {1'b0, req_addr} + {30'd0, size_bytes(req_sz)};
        req_bad = (req_sz == SZ_ILL)
                | ((req_sz == SZ_HALF) & req_addr[0])
                | ((req_sz == SZ_WORD) & (req_addr[1:0] != 2'b00))
                | (req_end > {1'b0, MEM_BYTES});
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        ready_d      = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_sz;
                    uns_d   = req_unsigned;
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata[15:0];
                    ready_d = 1'b0;
                    if (req_bad) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d    = ACCESS;
                        mem_addr_d = {req_addr[31:2], 2'b00};
                        if (req_we && req_sz == SZ_WORD) begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = req_wdata;
                        end
                    end
                end
            end
            ACCESS: begin
                if (we_q && size_q != SZ_WORD) begin
                    // merged word is built from the read data here and held for the WRITE cycle
                    state_d     = WRITE;
                    mem_addr_d  = mem_addr_q;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merge_data;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? '0 : load_data;
                end
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= SZ_BYTE;
            uns_q        <= 1'b0;
            off_q        <= '0;
            wdata_q      <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready      = ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign mem_write_en   = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Directed bench for lsu_dmem_port with a small behavioural dmem attached.
module tb_lsu_dmem_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:7];
    int unsigned we_total = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    lsu_dmem_port #(.MEM_BYTES(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_write_en   (mem_write_en),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = (mem_addr < 32'd32) ? mem[mem_addr[4:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_write_en === 1'b1) begin
            if (mem_addr < 32'd32) mem[mem_addr[4:2]] <= mem_write_data;
            we_total <= we_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 with the unit idle; checks response, latency and write-enable count.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_wes);
        int          lat;
        int unsigned we_start;
        we_start     = we_total;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".lat"},   32'(lat), 32'(exp_lat));
        check({tag, ".rdata"}, resp_rdata, exp_rdata);
        check({tag, ".err"},   {31'd0, resp_err}, {31'd0, exp_err});
        check({tag, ".busy"},  {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, ".wes"},   32'(we_total - we_start), 32'(exp_wes));
        check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, ".rvoff"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.ready", {31'd0, req_ready}, 32'd1);
        check("rst.rv",    {31'd0, resp_valid}, 32'd0);
        check("rst.rdata", resp_rdata, 32'h0);
        check("rst.err",   {31'd0, resp_err}, 32'd0);
        check("rst.we",    {31'd0, mem_write_en}, 32'd0);
        check("rst.addr",  mem_addr, 32'h0);
        check("rst.wdata", mem_write_data, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // word store / load and byte RMW
        do_req("sw4",  1'b1, 2'b10, 1'b0, 32'h04, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
        check("sw4.mem", mem[1], 32'hDEADBEEF);
        do_req("lw4",  1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
        do_req("sb6",  1'b1, 2'b00, 1'b0, 32'h06, 32'h1234565A, 32'h0, 1'b0, 3, 1);
        check("sb6.mem", mem[1], 32'hDE5ABEEF);

        // extension
        do_req("lb7s", 1'b0, 2'b00, 1'b0, 32'h07, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 0);
        do_req("lb7u", 1'b0, 2'b00, 1'b1, 32'h07, 32'h0, 32'h000000DE, 1'b0, 2, 0);
        do_req("lh4s", 1'b0, 2'b01, 1'b0, 32'h04, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 0);
        do_req("lh6u", 1'b0, 2'b01, 1'b1, 32'h06, 32'h0, 32'h0000DE5A, 1'b0, 2, 0);
        do_req("lb5s", 1'b0, 2'b00, 1'b0, 32'h05, 32'h0, 32'hFFFFFFBE, 1'b0, 2, 0);
        do_req("shA",  1'b1, 2'b01, 1'b0, 32'h0A, 32'hFFFF1234, 32'h0, 1'b0, 3, 1);
        check("shA.mem", mem[2], 32'h12340000);

        // rejected requests
        do_req("lh5",  1'b0, 2'b01, 1'b0, 32'h05, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("sw6",  1'b1, 2'b10, 1'b0, 32'h06, 32'h01020304, 32'h0, 1'b1, 1, 0);
        check("sw6.mem", mem[1], 32'hDE5ABEEF);
        do_req("sz11", 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 1, 0);

        // bounds
        do_req("sw1C", 1'b1, 2'b10, 1'b0, 32'h1C, 32'hAABBCCDD, 32'h0, 1'b0, 2, 1);
        do_req("lw1C", 1'b0, 2'b10, 1'b0, 32'h1C, 32'h0, 32'hAABBCCDD, 1'b0, 2, 0);
        do_req("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("lh1E", 1'b0, 2'b01, 1'b1, 32'h1E, 32'h0, 32'h0000AABB, 1'b0, 2, 0);
        do_req("lb1F", 1'b0, 2'b00, 1'b1, 32'h1F, 32'h0, 32'h000000AA, 1'b0, 2, 0);
        do_req("sb20", 1'b1, 2'b00, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("lwFC", 1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, 1, 0);

        // reset asserted during the WRITE cycle of a byte store
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h04;
        req_wdata = 32'h00000077;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rstw.we_pre", {31'd0, mem_write_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstw.we",    {31'd0, mem_write_en}, 32'd0);
        check("rstw.addr",  mem_addr, 32'h0);
        check("rstw.ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rstw.mem",   mem[1], 32'hDE5ABEEF);
        check("rstw.ready2", {31'd0, req_ready}, 32'd1);
        do_req("lw4b", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'hDE5ABEEF, 1'b0, 2, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
